// File: rtl/stream_demux_1to2.sv
// Registered 1-to-2 stream demultiplexer: each beat is steered by in_sel into one of
// two independent DEPTH-entry FIFOs, so a stalled sink never blocks the other sink.
module stream_demux_1to2 #(
    parameter int DWIDTH = 32,
    parameter int DEPTH  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DWIDTH-1:0] in_data,
    input  logic              in_sel,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DWIDTH-1:0] out0_data,
    output logic              out0_valid,
    input  logic              out0_ready,
    output logic [DWIDTH-1:0] out1_data,
    output logic              out1_valid,
    input  logic              out1_ready
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE  = {{AW{1'b0}}, 1'b1};
    localparam logic [AW-1:0] PTR_ONE  = {{(AW-1){1'b0}}, 1'b1};

    logic [DWIDTH-1:0] mem_q    [2][DEPTH];
    logic [AW-1:0]     wr_ptr_q [2];
    logic [AW-1:0]     wr_ptr_d [2];
    logic [AW-1:0]     rd_ptr_q [2];
    logic [AW-1:0]     rd_ptr_d [2];
    logic [AW:0]       cnt_q    [2];
    logic [AW:0]       cnt_d    [2];

    logic [1:0] full;
    logic [1:0] nonempty;
    logic [1:0] push;
    logic [1:0] pop;
    logic [1:0] out_rdy;

    assign out_rdy = {out1_ready, out0_ready};

    // Acceptance depends only on the addressed FIFO's fill level, never on in_valid.
    assign in_ready = !full[in_sel];

    always_comb begin
        for (int unsigned n = 0; n < 2; n++) begin
            full[n]     = (cnt_q[n] == CNT_FULL);
            nonempty[n] = (cnt_q[n] != '0);
        end
        push[0] = in_valid && !in_sel && !full[0];
        push[1] = in_valid &&  in_sel && !full[1];
        for (int unsigned n = 0; n < 2; n++) begin
            pop[n]      = nonempty[n] && out_rdy[n];
            wr_ptr_d[n] = push[n] ? wr_ptr_q[n] + PTR_ONE : wr_ptr_q[n];
            rd_ptr_d[n] = pop[n]  ? rd_ptr_q[n] + PTR_ONE : rd_ptr_q[n];
            cnt_d[n]    = cnt_q[n];
            case ({push[n], pop[n]})
                2'b10:   cnt_d[n] = cnt_q[n] + CNT_ONE;
                2'b01:   cnt_d[n] = cnt_q[n] - CNT_ONE;
                default: cnt_d[n] = cnt_q[n];
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned n = 0; n < 2; n++) begin
                wr_ptr_q[n] <= '0;
                rd_ptr_q[n] <= '0;
                cnt_q[n]    <= '0;
                for (int unsigned e = 0; e < DEPTH; e++) begin
                    mem_q[n][e] <= '0;
                end
            end
        end else begin
            for (int unsigned n = 0; n < 2; n++) begin
                wr_ptr_q[n] <= wr_ptr_d[n];
                rd_ptr_q[n] <= rd_ptr_d[n];
                cnt_q[n]    <= cnt_d[n];
                if (push[n]) begin
                    mem_q[n][wr_ptr_q[n]] <= in_data;
                end
            end
        end
    end

    // Heads read straight from storage registers: no combinational in->out path.
    assign out0_data  = mem_q[0][rd_ptr_q[0]];
    assign out1_data  = mem_q[1][rd_ptr_q[1]];
    assign out0_valid = nonempty[0];
    assign out1_valid = nonempty[1];

endmodule

// File: tb/tb_stream_demux_1to2.sv
// Directed and randomized self-checking bench for stream_demux_1to2.
module tb_stream_demux_1to2;

    logic        clk;
    logic        rst_n;
    logic [31:0] in_data;
    logic        in_sel;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] out0_data;
    logic        out0_valid;
    logic        out0_ready;
    logic [31:0] out1_data;
    logic        out1_valid;
    logic        out1_ready;

    int checks;
    int errors;

    stream_demux_1to2 #(.DWIDTH(32), .DEPTH(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_data    (in_data),
        .in_sel     (in_sel),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out0_data  (out0_data),
        .out0_valid (out0_valid),
        .out0_ready (out0_ready),
        .out1_data  (out1_data),
        .out1_valid (out1_valid),
        .out1_ready (out1_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; in_sel = 1'b0; in_data = '0;
        out0_ready = 1'b0; out1_ready = 1'b0;
        #3;
        checks++; if (out0_valid !== 1'b0) begin errors++; $display("FAIL reset_out0_valid got %b want 0", out0_valid); end
        checks++; if (out1_valid !== 1'b0) begin errors++; $display("FAIL reset_out1_valid got %b want 0", out1_valid); end
        checks++; if (out0_data !== 32'h0) begin errors++; $display("FAIL reset_out0_data got %h want 0", out0_data); end
        tick();
        rst_n = 1'b1;
        in_valid = 1'b1; in_sel = 1'b0; in_data = 32'hAAAA0001;
        tick();
        in_data = 32'hAAAA0002;
        tick();
        in_valid = 1'b0;
        checks++; if (out0_valid !== 1'b1 || out0_data !== 32'hAAAA0001) begin errors++; $display("FAIL prereset_fill got v=%b d=%h want v=1 d=aaaa0001", out0_valid, out0_data); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (out0_valid !== 1'b0) begin errors++; $display("FAIL async_reset_out0_valid got %b want 0", out0_valid); end
        checks++; if (out1_valid !== 1'b0) begin errors++; $display("FAIL async_reset_out1_valid got %b want 0", out1_valid); end
        checks++; if (out0_data !== 32'h0 || out1_data !== 32'h0) begin errors++; $display("FAIL async_reset_data got %h/%h want 0/0", out0_data, out1_data); end
        tick();
        rst_n = 1'b1;
        tick();
        checks++; if (out0_valid !== 1'b0) begin errors++; $display("FAIL reset_discard got out0_valid=%b want 0", out0_valid); end
    endtask

    task automatic test_route();
        out0_ready = 1'b1; out1_ready = 1'b1;
        in_valid = 1'b1; in_sel = 1'b0; in_data = 32'hFFFFFFFF;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL route_ready0 got %b want 1", in_ready); end
        tick();
        checks++; if (out0_valid !== 1'b1 || out0_data !== 32'hFFFFFFFF) begin errors++; $display("FAIL route_out0 got v=%b d=%h want v=1 d=ffffffff", out0_valid, out0_data); end
        checks++; if (out1_valid !== 1'b0) begin errors++; $display("FAIL route_out1_idle got %b want 0", out1_valid); end
        in_sel = 1'b1; in_data = 32'hEEEEEEEE;
        tick();
        checks++; if (out1_valid !== 1'b1 || out1_data !== 32'hEEEEEEEE) begin errors++; $display("FAIL route_out1 got v=%b d=%h want v=1 d=eeeeeeee", out1_valid, out1_data); end
        checks++; if (out0_valid !== 1'b0) begin errors++; $display("FAIL route_out0_popped got %b want 0", out0_valid); end
        in_valid = 1'b0;
        tick();
        checks++; if (out1_valid !== 1'b0) begin errors++; $display("FAIL route_out1_popped got %b want 0", out1_valid); end
    endtask

    task automatic test_backpressure();
        out0_ready = 1'b0; out1_ready = 1'b1;
        in_valid = 1'b1; in_sel = 1'b0; in_data = 32'h01234567;
        tick();
        in_data = 32'h89ABCDEF;
        tick();
        in_data = 32'h13579BDF;
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_full_ready got %b want 0", in_ready); end
        checks++; if (out0_valid !== 1'b1 || out0_data !== 32'h01234567) begin errors++; $display("FAIL bp_out0_head got v=%b d=%h want v=1 d=01234567", out0_valid, out0_data); end
        in_sel = 1'b1; in_data = 32'hFEDCBA98;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_other_ready got %b want 1", in_ready); end
        tick();
        checks++; if (out1_valid !== 1'b1 || out1_data !== 32'hFEDCBA98) begin errors++; $display("FAIL bp_out1 got v=%b d=%h want v=1 d=fedcba98", out1_valid, out1_data); end
        checks++; if (out0_data !== 32'h01234567) begin errors++; $display("FAIL bp_out0_stable got %h want 01234567", out0_data); end
    endtask

    task automatic test_drain();
        in_valid = 1'b1; in_sel = 1'b0; in_data = 32'h13579BDF;
        out0_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL drain_full_while_pop got %b want 0", in_ready); end
        tick();
        checks++; if (out0_valid !== 1'b1 || out0_data !== 32'h89ABCDEF) begin errors++; $display("FAIL drain_second got v=%b d=%h want v=1 d=89abcdef", out0_valid, out0_data); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL drain_ready_after_pop got %b want 1", in_ready); end
        checks++; if (out1_valid !== 1'b0) begin errors++; $display("FAIL drain_out1_popped got %b want 0", out1_valid); end
        tick();
        checks++; if (out0_valid !== 1'b1 || out0_data !== 32'h13579BDF) begin errors++; $display("FAIL drain_third got v=%b d=%h want v=1 d=13579bdf", out0_valid, out0_data); end
        in_valid = 1'b0;
        tick();
        checks++; if (out0_valid !== 1'b0) begin errors++; $display("FAIL drain_empty got %b want 0", out0_valid); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp;
        out0_ready = 1'b1; out1_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            exp = 32'hC0DE0000 + 32'(i);
            in_valid = 1'b1; in_sel = i[0]; in_data = exp;
            #1;
            checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready[%0d] got %b want 1", i, in_ready); end
            tick();
            if (i[0]) begin
                checks++; if (out1_valid !== 1'b1 || out1_data !== exp) begin errors++; $display("FAIL b2b_out1[%0d] got v=%b d=%h want v=1 d=%h", i, out1_valid, out1_data, exp); end
            end else begin
                checks++; if (out0_valid !== 1'b1 || out0_data !== exp) begin errors++; $display("FAIL b2b_out0[%0d] got v=%b d=%h want v=1 d=%h", i, out0_valid, out0_data, exp); end
            end
        end
        in_valid = 1'b0;
        tick();
        checks++; if (out0_valid !== 1'b0 || out1_valid !== 1'b0) begin errors++; $display("FAIL b2b_empty got %b%b want 00", out1_valid, out0_valid); end
    endtask

    task automatic test_random();
        logic [31:0] q0[$];
        logic [31:0] q1[$];
        logic        exp_rdy;
        logic        prev_stall0, prev_stall1;
        logic [31:0] prev_d0, prev_d1;
        int          rnd_err;
        rnd_err = 0;
        prev_stall0 = 1'b0; prev_stall1 = 1'b0;
        prev_d0 = '0; prev_d1 = '0;
        for (int c = 0; c < 10000; c++) begin
            in_valid   = ($urandom_range(0, 3) != 0);
            in_sel     = 1'($urandom_range(0, 1));
            in_data    = $urandom;
            out0_ready = ($urandom_range(0, 2) != 0);
            out1_ready = ($urandom_range(0, 2) != 0);
            #1;
            exp_rdy = in_sel ? (q1.size() < 2) : (q0.size() < 2);
            checks++;
            if (in_ready !== exp_rdy || out0_valid !== (q0.size() > 0) || out1_valid !== (q1.size() > 0)) begin
                errors++; rnd_err++;
                if (rnd_err < 20) $display("FAIL rnd_flags[%0d] got rdy=%b v0=%b v1=%b want rdy=%b v0=%b v1=%b", c, in_ready, out0_valid, out1_valid, exp_rdy, q0.size() > 0, q1.size() > 0);
            end
            if (q0.size() > 0) begin
                checks++;
                if (out0_data !== q0[0]) begin errors++; rnd_err++; if (rnd_err < 20) $display("FAIL rnd_out0[%0d] got %h want %h", c, out0_data, q0[0]); end
            end
            if (q1.size() > 0) begin
                checks++;
                if (out1_data !== q1[0]) begin errors++; rnd_err++; if (rnd_err < 20) $display("FAIL rnd_out1[%0d] got %h want %h", c, out1_data, q1[0]); end
            end
            if (prev_stall0) begin
                checks++;
                if (out0_data !== prev_d0) begin errors++; rnd_err++; if (rnd_err < 20) $display("FAIL rnd_stable0[%0d] got %h want %h", c, out0_data, prev_d0); end
            end
            if (prev_stall1) begin
                checks++;
                if (out1_data !== prev_d1) begin errors++; rnd_err++; if (rnd_err < 20) $display("FAIL rnd_stable1[%0d] got %h want %h", c, out1_data, prev_d1); end
            end
            prev_stall0 = (q0.size() > 0) && !out0_ready; prev_d0 = out0_data;
            prev_stall1 = (q1.size() > 0) && !out1_ready; prev_d1 = out1_data;
            if (q0.size() > 0 && out0_ready) void'(q0.pop_front());
            if (q1.size() > 0 && out1_ready) void'(q1.pop_front());
            if (in_valid && exp_rdy) begin
                if (in_sel) q1.push_back(in_data); else q0.push_back(in_data);
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_route();
        test_backpressure();
        test_drain();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
